// File: rtl/fwd_scoreboard_if.sv
// Operand/forwarding bundle between the decode stage and the forwarding scoreboard.
// The decode-side driver uses master; the scoreboard uses slave.
interface fwd_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NSRC   = 2,
  parameter int DEPTH  = 3,
  parameter int TN_W   = 2,
  parameter int SEL_W  = 2
);
  logic                    issue_valid;
  logic [ADDR_W-1:0]       issue_dst;
  logic [TN_W-1:0]         issue_tnew;
  logic [NSRC*ADDR_W-1:0]  src_addr;
  logic [NSRC*TN_W-1:0]    src_tuse;
  logic [NSRC*DATA_W-1:0]  src_rf_data;
  logic [DEPTH*DATA_W-1:0] stage_data;
  logic                    stall;
  logic [NSRC*SEL_W-1:0]   src_fwd_sel;
  logic [NSRC*DATA_W-1:0]  src_fwd_data;
  logic [NSRC-1:0]         src_pending;
  logic [DEPTH-1:0]        stage_valid;

  modport master (
    output issue_valid, issue_dst, issue_tnew, src_addr, src_tuse, src_rf_data, stage_data,
    input  stall, src_fwd_sel, src_fwd_data, src_pending, stage_valid
  );

  modport slave (
    input  issue_valid, issue_dst, issue_tnew, src_addr, src_tuse, src_rf_data, stage_data,
    output stall, src_fwd_sel, src_fwd_data, src_pending, stage_valid
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// Forwarding and stall unit: tracks in-flight destinations with remaining latency
// and resolves each decode-stage operand to register file, a stage bus, or a stall.
module fwd_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NSRC   = 2,
  parameter int DEPTH  = 3,
  parameter int TN_W   = 2,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  fwd_scoreboard_if.slave   sb
);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] dst;
    logic [TN_W-1:0]   tnew;
  } entry_t;

  entry_t [DEPTH-1:0]      ent_q;
  entry_t [DEPTH-1:0]      ent_d;

  logic [NSRC-1:0]         stall_req;
  logic                    stall_int;
  logic [NSRC*SEL_W-1:0]   sel_c;
  logic [NSRC*DATA_W-1:0]  data_c;
  logic [NSRC-1:0]         pend_c;
  logic [DEPTH-1:0]        valid_c;

  logic [ADDR_W-1:0]       addr_c;
  logic [TN_W-1:0]         tuse_c;
  logic                    hit_c;
  logic [SEL_W-1:0]        hitSel_c;
  logic [TN_W-1:0]         hitTnew_c;
  logic [DATA_W-1:0]       hitData_c;

  // A stall turns entry 0 into a bubble so older producers keep draining.
  always_comb begin
    ent_d = '0;
    if (!stall_int) begin
      ent_d[0].valid = sb.issue_valid && (sb.issue_dst != '0);
      ent_d[0].dst   = sb.issue_dst;
      ent_d[0].tnew  = sb.issue_tnew;
    end
    for (int k = 1; k < DEPTH; k++) begin
      ent_d[k].valid = ent_q[k-1].valid;
      ent_d[k].dst   = ent_q[k-1].dst;
      ent_d[k].tnew  = (ent_q[k-1].tnew == '0) ? '0 : ent_q[k-1].tnew - TN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end

  // Scanning from the oldest stage down lets the youngest producer overwrite older hits.
  always_comb begin
    sel_c     = '0;
    data_c    = sb.src_rf_data;
    pend_c    = '0;
    stall_req = '0;
    addr_c    = '0;
    tuse_c    = '0;
    hit_c     = 1'b0;
    hitSel_c  = '0;
    hitTnew_c = '0;
    hitData_c = '0;
    for (int i = 0; i < NSRC; i++) begin
      addr_c    = sb.src_addr[i*ADDR_W +: ADDR_W];
      tuse_c    = sb.src_tuse[i*TN_W +: TN_W];
      hit_c     = 1'b0;
      hitSel_c  = '0;
      hitTnew_c = '0;
      hitData_c = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (ent_q[k].valid && (ent_q[k].dst == addr_c)) begin
          hit_c     = 1'b1;
          hitSel_c  = SEL_W'(k + 1);
          hitTnew_c = ent_q[k].tnew;
          hitData_c = sb.stage_data[k*DATA_W +: DATA_W];
        end
      end
      if ((addr_c != '0) && hit_c) begin
        if (hitTnew_c == '0) begin
          sel_c[i*SEL_W +: SEL_W]    = hitSel_c;
          data_c[i*DATA_W +: DATA_W] = hitData_c;
        end else if (hitTnew_c <= tuse_c) begin
          pend_c[i] = 1'b1;
        end else begin
          stall_req[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    valid_c = '0;
    for (int k = 0; k < DEPTH; k++) begin
      valid_c[k] = ent_q[k].valid;
    end
  end

  assign stall_int       = |stall_req;
  assign sb.stall        = stall_int;
  assign sb.src_fwd_sel  = sel_c;
  assign sb.src_fwd_data = data_c;
  assign sb.src_pending  = pend_c;
  assign sb.stage_valid  = valid_c;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: the driver queues expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_fwd_scoreboard;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NSRC   = 2;
  localparam int DEPTH  = 3;
  localparam int TN_W   = 2;
  localparam int SEL_W  = 2;

  localparam logic [31:0] RF0 = 32'h0000_0F00;
  localparam logic [31:0] RF1 = 32'h0000_0F11;
  localparam logic [31:0] SE  = 32'h1111_0000;
  localparam logic [31:0] SM  = 32'h2222_0000;
  localparam logic [31:0] SW  = 32'h3333_0000;

  typedef struct packed {
    int                     cyc;
    logic                   stall;
    logic [NSRC*SEL_W-1:0]  sel;
    logic [NSRC*DATA_W-1:0] data;
    logic [NSRC-1:0]        pend;
    logic [DEPTH-1:0]       sv;
  } expT;

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  int    cycleCount = 0;
  int    checks = 0;
  int    passes = 0;
  expT   expQ[$];
  string nameQ[$];

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  fwd_scoreboard_if #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NSRC(NSRC),
    .DEPTH(DEPTH), .TN_W(TN_W), .SEL_W(SEL_W)
  ) sb ();

  fwd_scoreboard #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NSRC(NSRC),
    .DEPTH(DEPTH), .TN_W(TN_W), .SEL_W(SEL_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sb(sb)
  );

  task automatic applyStimulus(input logic iv, input logic [4:0] dst, input logic [1:0] tnew,
                               input logic [4:0] a1, input logic [4:0] a0,
                               input logic [1:0] u1, input logic [1:0] u0);
    sb.issue_valid = iv;
    sb.issue_dst   = dst;
    sb.issue_tnew  = tnew;
    sb.src_addr    = {a1, a0};
    sb.src_tuse    = {u1, u0};
  endtask

  task automatic setStage(input logic [31:0] w, input logic [31:0] m, input logic [31:0] e);
    sb.stage_data = {w, m, e};
  endtask

  task automatic expectNow(input string name, input logic st,
                           input logic [1:0] s1, input logic [1:0] s0,
                           input logic [31:0] d1, input logic [31:0] d0,
                           input logic [1:0] pend, input logic [2:0] sv);
    expT e;
    e.cyc   = cycleCount;
    e.stall = st;
    e.sel   = {s1, s0};
    e.data  = {d1, d0};
    e.pend  = pend;
    e.sv    = sv;
    expQ.push_back(e);
    nameQ.push_back(name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmpField(input string name, input string field,
                          input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s.%s: got %h, expected %h", name, field, act, req);
    end
  endtask

  task automatic checkOutput(input expT e, input string name);
    cmpField(name, "stall",   64'(sb.stall),        64'(e.stall));
    cmpField(name, "sel",     64'(sb.src_fwd_sel),  64'(e.sel));
    cmpField(name, "data",    64'(sb.src_fwd_data), 64'(e.data));
    cmpField(name, "pending", 64'(sb.src_pending),  64'(e.pend));
    cmpField(name, "valid",   64'(sb.stage_valid),  64'(e.sv));
  endtask

  // Monitor: compares mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    expT   e;
    string n;
    while (expQ.size() > 0 && expQ[0].cyc < cycleCount) begin
      e = expQ.pop_front();
      n = nameQ.pop_front();
      checks++;
      $display("[TB] FAIL %s: expectation for cycle %0d not sampled, now cycle %0d", n, e.cyc, cycleCount);
    end
    if (expQ.size() > 0 && expQ[0].cyc == cycleCount) begin
      e = expQ.pop_front();
      n = nameQ.pop_front();
      checkOutput(e, n);
    end
  end

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    setStage(SW, SM, SE);
    sb.src_rf_data = {RF1, RF0};
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    applyStimulus(0, 0, 0, 3, 2, 0, 0);
    expectNow("reset", 0, 0, 0, RF1, RF0, 2'b00, 3'b000);
    step();

    applyStimulus(1, 8, 0, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 3, 8, 0, 0);
    setStage(SW, SM, 32'h0000_1234);
    expectNow("aluE", 0, 0, 1, RF1, 32'h0000_1234, 2'b00, 3'b001);
    step();
    setStage(SW, SM, SE);
    expectNow("aluM", 0, 0, 2, RF1, SM, 2'b00, 3'b010);
    step();
    expectNow("aluW", 0, 0, 3, RF1, SW, 2'b00, 3'b100);
    step();
    expectNow("aluGone", 0, 0, 0, RF1, RF0, 2'b00, 3'b000);

    applyStimulus(1, 9, 2, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 9, 0, 0);
    expectNow("ldStall1", 1, 0, 0, RF1, RF0, 2'b00, 3'b001);
    step();
    expectNow("ldStall2", 1, 0, 0, RF1, RF0, 2'b00, 3'b010);
    step();
    expectNow("ldFwdW", 0, 0, 3, RF1, SW, 2'b00, 3'b100);
    step();

    applyStimulus(1, 9, 2, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 9, 0, 1);
    expectNow("ldT1Stall", 1, 0, 0, RF1, RF0, 2'b00, 3'b001);
    step();
    expectNow("ldT1Pend", 0, 0, 0, RF1, RF0, 2'b01, 3'b010);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    step();

    applyStimulus(1, 4, 0, 0, 0, 0, 0);
    step();
    step();
    applyStimulus(0, 0, 0, 4, 4, 0, 0);
    setStage(SW, 32'h0000_AAAA, 32'h0000_BBBB);
    expectNow("youngest", 0, 1, 1, 32'h0000_BBBB, 32'h0000_BBBB, 2'b00, 3'b011);
    step();
    expectNow("youngestM", 0, 2, 2, 32'h0000_AAAA, 32'h0000_AAAA, 2'b00, 3'b110);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    setStage(SW, SM, SE);
    step();

    applyStimulus(1, 5, 0, 0, 0, 0, 0);
    step();
    applyStimulus(1, 6, 1, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 6, 5, 1, 0);
    expectNow("mixed", 0, 0, 2, RF1, SM, 2'b10, 3'b011);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    step();
    step();

    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    expectNow("dstZero", 0, 0, 0, RF1, RF0, 2'b00, 3'b000);
    step();

    applyStimulus(1, 7, 1, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 7, 0, 0);
    expectNow("preReset", 1, 0, 0, RF1, RF0, 2'b00, 3'b001);
    reset = 1'b1;
    step();
    reset = 1'b0;
    expectNow("postReset", 0, 0, 0, RF1, RF0, 2'b00, 3'b000);
    step();
    step();

    if (expQ.size() != 0) begin
      checks += expQ.size();
      $display("[TB] FAIL leftover: %0d expectations unchecked, expected 0", expQ.size());
    end
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
